// File: rtl/lab4_sramword_pkg.sv
// Shared types and default sizing for the single-word SRAM access controller.
package lab4_sramword_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ACC,
    SENSE,
    DONE
  } state_t;

  localparam int DEF_WORD_BITS    = 8;
  localparam int DEF_PRE_CYCLES   = 2;
  localparam int DEF_WL_CYCLES    = 2;
  localparam int DEF_SENSE_CYCLES = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lab4_sramword_phase_cnt.sv
// Loadable down-counter timing each FSM phase; last is high on the final cycle of a phase.
module lab4_sramword_phase_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          last
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/lab4_sramword_ctrl.sv
// Access sequencer for one analog SRAM word: precharge, wordline, write drive, sense, capture.
// Define SRAMWORD_WRITE_VERIFY_EN to add a read-back verify pass after every write.
module lab4_sramword_ctrl
  import lab4_sramword_pkg::*;
#(
  parameter int WORD_BITS    = DEF_WORD_BITS,
  parameter int PRE_CYCLES   = DEF_PRE_CYCLES,
  parameter int WL_CYCLES    = DEF_WL_CYCLES,
  parameter int SENSE_CYCLES = DEF_SENSE_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wordline,
  input  logic                 wen,
  input  logic [WORD_BITS-1:0] data_in,
  input  logic [WORD_BITS-1:0] sa_out,
  output logic                 pre_en,
  output logic                 wl_en,
  output logic                 wdrv_en,
  output logic [WORD_BITS-1:0] wdata,
  output logic                 sae,
  output logic [WORD_BITS-1:0] data_out,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 wr_err
);

  localparam int CW = $clog2(max3(PRE_CYCLES, WL_CYCLES, SENSE_CYCLES) + 1);

  state_t        state, nxt;
  logic          wen_q;
  logic          load, last;
  logic [CW-1:0] load_val;
`ifdef SRAMWORD_WRITE_VERIFY_EN
  logic          vfy, vfy_nxt;
`endif

  lab4_sramword_phase_cnt #(.CW(CW)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .last     (last)
  );

  always_comb begin
    nxt      = state;
    load_val = '0;
`ifdef SRAMWORD_WRITE_VERIFY_EN
    vfy_nxt  = vfy;
`endif
    case (state)
      IDLE: if (wordline) begin
        nxt      = PRE;
        load_val = CW'(PRE_CYCLES - 1);
      end
      PRE: if (last) begin
        nxt      = ACC;
        load_val = CW'(WL_CYCLES - 1);
      end
      ACC: if (last) begin
        if (!wen_q) begin
          nxt      = SENSE;
          load_val = CW'(SENSE_CYCLES - 1);
        end
`ifdef SRAMWORD_WRITE_VERIFY_EN
        // First write pass re-precharges, then reads the cell back with drivers off.
        else if (!vfy) begin
          nxt      = PRE;
          vfy_nxt  = 1'b1;
          load_val = CW'(PRE_CYCLES - 1);
        end else begin
          nxt      = SENSE;
          load_val = CW'(SENSE_CYCLES - 1);
        end
`else
        else begin
          nxt = DONE;
        end
`endif
      end
      SENSE: if (last) nxt = DONE;
      DONE: begin
        nxt = IDLE;
`ifdef SRAMWORD_WRITE_VERIFY_EN
        vfy_nxt = 1'b0;
`endif
      end
      default: nxt = IDLE;
    endcase
  end

  // Every state change restarts the phase timer.
  assign load = (nxt != state);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wen_q    <= 1'b0;
      pre_en   <= 1'b1;
      wl_en    <= 1'b0;
      wdrv_en  <= 1'b0;
      sae      <= 1'b0;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      wdata    <= '0;
      data_out <= '0;
`ifdef SRAMWORD_WRITE_VERIFY_EN
      vfy      <= 1'b0;
      wr_err   <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (state == IDLE && wordline) begin
        wen_q <= wen;
        wdata <= data_in;
      end
      // Outputs decode the state being entered so they line up with it.
      pre_en   <= (nxt == IDLE) || (nxt == PRE) || (nxt == DONE);
      wl_en    <= (nxt == ACC) || (nxt == SENSE);
      sae      <= (nxt == SENSE);
      busy     <= (nxt != IDLE);
      rd_valid <= (nxt == DONE) && !wen_q;
      if (state == SENSE && last && !wen_q) data_out <= sa_out;
`ifdef SRAMWORD_WRITE_VERIFY_EN
      vfy      <= vfy_nxt;
      wdrv_en  <= (nxt == ACC) && wen_q && !vfy_nxt;
      wr_err   <= (state == SENSE) && last && wen_q && (sa_out != wdata);
`else
      wdrv_en  <= (nxt == ACC) && wen_q;
`endif
    end
  end

`ifndef SRAMWORD_WRITE_VERIFY_EN
  assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_lab4_sramword_ctrl.sv
// Directed bench for lab4_sramword_ctrl with a read-data scoreboard and per-cycle phase model.
module tb_lab4_sramword_ctrl;

  localparam int P   = 2;
  localparam int WLC = 2;
  localparam int S   = 1;
`ifdef SRAMWORD_WRITE_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, wordline, wen;
  logic [7:0] data_in, sa_out;
  logic       pre_en, wl_en, wdrv_en, sae, rd_valid, busy, wr_err;
  logic [7:0] wdata, data_out;

  int         nassert = 0;
  int         nfail   = 0;
  logic [7:0] sb[$];
  logic [7:0] last_rd = 8'h00;

  lab4_sramword_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .wordline (wordline),
    .wen      (wen),
    .data_in  (data_in),
    .sa_out   (sa_out),
    .pre_en   (pre_en),
    .wl_en    (wl_en),
    .wdrv_en  (wdrv_en),
    .wdata    (wdata),
    .sae      (sae),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .busy     (busy),
    .wr_err   (wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // 0 PRE, 1 ACC with drivers, 2 ACC no drivers, 3 SENSE, 4 DONE
  function automatic int phase(input bit w, input int c);
    if (!w) begin
      if (c <= P) return 0;
      if (c <= P + WLC) return 2;
      if (c <= P + WLC + S) return 3;
      return 4;
    end
    if (!VFY) begin
      if (c <= P) return 0;
      if (c <= P + WLC) return 1;
      return 4;
    end
    if (c <= P) return 0;
    if (c <= P + WLC) return 1;
    if (c <= 2*P + WLC) return 0;
    if (c <= 2*P + 2*WLC) return 2;
    if (c <= 2*P + 2*WLC + S) return 3;
    return 4;
  endfunction

  function automatic int lat(input bit w);
    if (!w) return P + WLC + S + 1;
    return VFY ? (2*P + 2*WLC + S + 1) : (P + WLC + 1);
  endfunction

  // Vector order: {pre_en, wl_en, wdrv_en, sae, busy, rd_valid, wr_err}
  task automatic run_op(input bit w, input logic [7:0] d, input logic [7:0] sa,
                        input bit hold, input bit poke, input string nm);
    int         len, ph;
    logic [6:0] e;
    len      = lat(w);
    wordline = 1'b1;
    wen      = w;
    data_in  = d;
    sa_out   = sa;
    if (!w) sb.push_back(sa);
    step;
    wordline = hold;
    wen      = ~w;
    data_in  = ~d;
    for (int c = 1; c <= len; c++) begin
      ph = phase(w, c);
      case (ph)
        0:       e = 7'b1000100;
        1:       e = 7'b0110100;
        2:       e = 7'b0100100;
        3:       e = 7'b0101100;
        default: e = {5'b10001, !w, VFY && w && (sa != d)};
      endcase
      chk($sformatf("%s_ctl_c%0d", nm, c),
          32'({pre_en, wl_en, wdrv_en, sae, busy, rd_valid, wr_err}), 32'(e));
      if (ph == 1) chk($sformatf("%s_wdata_c%0d", nm, c), 32'(wdata), 32'(d));
      if (ph == 4) begin
        if (!w) begin
          chk($sformatf("%s_dout", nm), 32'(data_out), 32'(sa));
          last_rd = sa;
        end else begin
          chk($sformatf("%s_dout_kept", nm), 32'(data_out), 32'(last_rd));
        end
      end
      if (poke) wordline = (c >= 2 && c < len);
      step;
    end
    chk($sformatf("%s_idle", nm), 32'({pre_en, busy, wl_en, rd_valid}), 32'(4'b1000));
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("no_pre_wl_overlap", 32'(pre_en & wl_en), 32'(0));
      chk("no_wdrv_sae_overlap", 32'(wdrv_en & sae), 32'(0));
      if (rd_valid === 1'b1) begin
        if (sb.size() == 0) chk("spurious_rd_valid", 32'(rd_valid), 32'(0));
        else chk("sb_data_out", 32'(data_out), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    reset    = 1'b1;
    wordline = 1'b0;
    wen      = 1'b0;
    data_in  = 8'h00;
    sa_out   = 8'h00;
    for (int i = 0; i < 3; i++) step;
    chk("reset_ctl", 32'({pre_en, wl_en, wdrv_en, sae, busy, rd_valid, wr_err}), 32'(7'b1000000));
    chk("reset_data", 32'({wdata, data_out}), 32'(0));
    reset = 1'b0;
    step;
    chk("post_reset_idle", 32'({pre_en, busy}), 32'(2'b10));

    run_op(1'b0, 8'h00, 8'h55, 1'b0, 1'b0, "rd55");
    run_op(1'b1, 8'hAA, 8'h00, 1'b0, 1'b0, "wrAA");

    // Read aborted by a reset held three cycles while the wordline is up.
    sa_out   = 8'h33;
    wordline = 1'b1;
    wen      = 1'b0;
    step;
    wordline = 1'b0;
    step;
    step;
    chk("abort_in_acc", 32'({pre_en, wl_en}), 32'(2'b01));
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      chk($sformatf("midrst_ctl_%0d", i),
          32'({pre_en, wl_en, wdrv_en, sae, busy, rd_valid, wr_err}), 32'(7'b1000000));
      chk($sformatf("midrst_dout_%0d", i), 32'(data_out), 32'(0));
    end
    reset   = 1'b0;
    last_rd = 8'h00;
    step;
    chk("after_midrst_idle", 32'({pre_en, busy, rd_valid}), 32'(3'b100));

    run_op(1'b0, 8'h12, 8'hC3, 1'b0, 1'b0, "rdC3");
    run_op(1'b0, 8'h00, 8'h5A, 1'b1, 1'b0, "b2b_rd");
    run_op(1'b1, 8'h3C, 8'h3C, 1'b0, 1'b0, "b2b_wr");
    run_op(1'b0, 8'h00, 8'hE7, 1'b0, 1'b1, "busy_req");
    step;
    chk("busy_req_ignored", 32'({busy, pre_en}), 32'(2'b01));

`ifdef SRAMWORD_WRITE_VERIFY_EN
    run_op(1'b1, 8'hFF, 8'hFE, 1'b0, 1'b0, "vfy_bad");
    run_op(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, "vfy_ok");
`endif

    step;
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
